vmx_tile_sched: RTL and testbench
=================================

// Module: vmx_tile_sched
// PURPOSE
//  Host-facing job scheduler for the VMX matrix-multiply engine. Accepts one command {rbase, wbase, strides, tile count}.
//  Launches the engine once per tile over its ctrl/flag interface, advancing read/write base addresses between tiles.
//  Reports completion, progress, and watchdog errors. Sits between the AXI-Lite register file and the engine wrapper.
// PARAMETERS
//  ADDR_W     8   width of buffer base addresses and strides
//  CNT_W      8   width of tile count / progress counter
//  TMO_W      12  watchdog width; timeout fires at 2**TMO_W-1 cycles in a wait state
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous, active-high reset
//  cmd_valid     in   1       command request
//  cmd_ready     out  1       high only in S_IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_rbase     in   ADDR_W  first tile read base
//  cmd_wbase     in   ADDR_W  first tile write base
//  cmd_rstride   in   ADDR_W  read-base increment per tile
//  cmd_wstride   in   ADDR_W  write-base increment per tile
//  cmd_ntiles    in   CNT_W   number of tiles; 0 = no-op
//  abort         in   1       level; cancels the running job
//  vmx_rbase     out  ADDR_W  engine read base (held stable while engine busy)
//  vmx_wbase     out  ADDR_W  engine write base
//  vmx_ctrl      out  32      {30'b0, start, soft_rst}
//  vmx_flag      in   32      engine status; [2:0] = engine state, 0 = idle
//  busy          out  1       high in every state except S_IDLE
//  done          out  1       1-cycle pulse on normal job completion
//  tiles_done    out  CNT_W   tiles completed in current/last job
//  err           out  1       sticky watchdog error; cleared on next command accept
//  perf_cycles   out  32      see CONFIGURATION
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state S_IDLE.
//  States and transitions:
//   S_IDLE:   accept cmd -> latch fields; tiles_done=0; err=0.
//             ntiles==0 -> done pulse next cycle, stay S_IDLE; else -> S_ISSUE.
//   S_ISSUE:  vmx_ctrl[1]=1 for exactly this one cycle -> S_WAIT_START.
//   S_WAIT_START: wait vmx_flag[2:0]!=0 -> S_WAIT_DONE.
//   S_WAIT_DONE:  wait vmx_flag[2:0]==0 -> S_NEXT.
//   S_NEXT:   tiles_done+=1.
//             If new value==ntiles -> done=1 (same cycle), -> S_IDLE.
//             Else rbase+=rstride, wbase+=wstride (mod 2**ADDR_W, wrap silently) -> S_ISSUE.
//   S_FLUSH:  vmx_ctrl[0]=1 for exactly 2 cycles, then -> S_IDLE; done not pulsed.
//  Latency: cmd accept to first start pulse = 1 cycle; tile end (flag->0) to next start = 2 cycles.
//  Watchdog: counter clears on entry to S_WAIT_START/S_WAIT_DONE and increments in them.
//   Reaching 2**TMO_W-1 -> err=1, -> S_FLUSH.
//  Abort:
//   In any busy state -> S_FLUSH next cycle; takes priority over watchdog and flag transitions in the same cycle.
//   Ignored in S_IDLE and during S_FLUSH.
//  tiles_done holds its final value after job end until next accept.
//  vmx_rbase/vmx_wbase change only in S_IDLE accept and S_NEXT.
//  Reset mid-job: immediate return to reset values; vmx_ctrl=0 (engine is reset by its own reset).
// CONFIGURATION
//  VMX_SCHED_PERF_EN defined:
//   perf_cycles counts cycles with busy=1; cleared on command accept; saturates at 32'hFFFFFFFF.
//  Undefined: perf_cycles tied to 0; no counter logic.
// TESTING
//  1. rbase=8'h00, wbase=8'h80, strides 4/8, ntiles=3, engine model busy 10 cycles
//     -> 3 start pulses; vmx_rbase 00/04/08; vmx_wbase 80/88/90; done once; tiles_done=3.
//  2. ntiles=0 -> done pulse 1 cycle after accept, no start pulse, busy stays 0.
//  3. rbase=8'hFC, rstride=4, ntiles=2 -> second tile vmx_rbase=8'h00 (wrap).
//  4. Engine never leaves idle, TMO_W=4 -> err=1 after 15 cycles in S_WAIT_START;
//     soft_rst high 2 cycles; no done; next accept clears err.
//  5. abort asserted in S_WAIT_DONE of tile 2 of 4 -> S_FLUSH; soft_rst 2 cycles; tiles_done=1; no done.
//  6. rst asserted mid-tile -> all outputs 0 and cmd_ready=1 asynchronously.
//     With VMX_SCHED_PERF_EN, test 1 perf_cycles equals busy-high cycle count.

Source files
------------

// File: rtl/vmx_tile_sched.sv
// Tile-by-tile job scheduler for the VMX matrix-multiply engine.
// Define VMX_SCHED_PERF_EN to enable the saturating busy-cycle counter on o_perf_cycles.
module vmx_tile_sched #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8,
    parameter int TMO_W  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_rbase,
    input  logic [ADDR_W-1:0] i_cmd_wbase,
    input  logic [ADDR_W-1:0] i_cmd_rstride,
    input  logic [ADDR_W-1:0] i_cmd_wstride,
    input  logic [CNT_W-1:0]  i_cmd_ntiles,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_vmx_rbase,
    output logic [ADDR_W-1:0] o_vmx_wbase,
    output logic [31:0]       o_vmx_ctrl,
    input  logic [31:0]       i_vmx_flag,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_tiles_done,
    output logic              o_err,
    output logic [31:0]       o_perf_cycles
);

    // state        | meaning
    // S_IDLE       | waiting for a command
    // S_ISSUE      | start pulse to engine
    // S_WAIT_START | waiting for engine to leave idle
    // S_WAIT_DONE  | waiting for engine to return to idle
    // S_NEXT       | count tile, advance bases or finish
    // S_FLUSH      | soft reset of engine after abort/timeout
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_START, S_WAIT_DONE, S_NEXT, S_FLUSH
    } state_t;

    // Compared against the pre-increment count, so the timeout lands on the (2**TMO_W-1)th wait cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2 ** TMO_W) - 2);

    state_t            r_state;
    logic [ADDR_W-1:0] r_rbase;
    logic [ADDR_W-1:0] r_wbase;
    logic [ADDR_W-1:0] r_rstride;
    logic [ADDR_W-1:0] r_wstride;
    logic [CNT_W-1:0]  r_ntiles;
    logic [CNT_W-1:0]  r_tiles;
    logic [TMO_W-1:0]  r_wdog;
    logic              r_flush_cnt;
    logic              r_start;
    logic              r_soft;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_eng_idle;
    logic              w_wdog_exp;
    logic [CNT_W-1:0]  w_tiles_nxt;
    logic              w_unused;

    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
    assign w_eng_idle  = (i_vmx_flag[2:0] == 3'd0);
    assign w_wdog_exp  = (r_wdog == TMO_LAST);
    assign w_tiles_nxt = r_tiles + 1'b1;
    assign w_unused    = ^i_vmx_flag[31:3];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_rbase     <= '0;
            r_wbase     <= '0;
            r_rstride   <= '0;
            r_wstride   <= '0;
            r_ntiles    <= '0;
            r_tiles     <= '0;
            r_wdog      <= '0;
            r_flush_cnt <= 1'b0;
            r_start     <= 1'b0;
            r_soft      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rbase   <= i_cmd_rbase;
                        r_wbase   <= i_cmd_wbase;
                        r_rstride <= i_cmd_rstride;
                        r_wstride <= i_cmd_wstride;
                        r_ntiles  <= i_cmd_ntiles;
                        r_tiles   <= '0;
                        r_err     <= 1'b0;
                        if (i_cmd_ntiles == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_abort) begin
                        r_soft <= 1'b1; r_flush_cnt <= 1'b0; r_state <= S_FLUSH;
                    end else begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (i_abort) begin
                        r_soft <= 1'b1; r_flush_cnt <= 1'b0; r_state <= S_FLUSH;
                    end else if (!w_eng_idle) begin
                        r_wdog  <= '0;
                        r_state <= S_WAIT_DONE;
                    end else if (w_wdog_exp) begin
                        r_err <= 1'b1;
                        r_soft <= 1'b1; r_flush_cnt <= 1'b0; r_state <= S_FLUSH;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_abort) begin
                        r_soft <= 1'b1; r_flush_cnt <= 1'b0; r_state <= S_FLUSH;
                    end else if (w_eng_idle) begin
                        r_state <= S_NEXT;
                    end else if (w_wdog_exp) begin
                        r_err <= 1'b1;
                        r_soft <= 1'b1; r_flush_cnt <= 1'b0; r_state <= S_FLUSH;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (i_abort) begin
                        r_soft <= 1'b1; r_flush_cnt <= 1'b0; r_state <= S_FLUSH;
                    end else begin
                        r_tiles <= w_tiles_nxt;
                        if (w_tiles_nxt == r_ntiles) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_rbase <= r_rbase + r_rstride;
                            r_wbase <= r_wbase + r_wstride;
                            r_start <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_FLUSH: begin
                    r_flush_cnt <= 1'b1;
                    if (r_flush_cnt) begin
                        r_soft      <= 1'b0;
                        r_flush_cnt <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef VMX_SCHED_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if ((r_state != S_IDLE) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign o_perf_cycles = r_perf;
`else
    assign o_perf_cycles = '0;
`endif

    assign o_cmd_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_vmx_rbase  = r_rbase;
    assign o_vmx_wbase  = r_wbase;
    assign o_vmx_ctrl   = {30'b0, r_start, r_soft};
    assign o_done       = r_done;
    assign o_tiles_done = r_tiles;
    assign o_err        = r_err;

endmodule

// File: tb/tb_vmx_tile_sched.sv
// Self-checking bench for vmx_tile_sched: table jobs, random jobs against an address/latency model,
// plus watchdog, abort and mid-job reset sequences. Engine is a small behavioural responder.
module tb_vmx_tile_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_rbase = '0, cmd_wbase = '0, cmd_rstride = '0, cmd_wstride = '0, cmd_ntiles = '0;
    logic        abort = 1'b0;
    logic [7:0]  vmx_rbase, vmx_wbase;
    logic [31:0] vmx_ctrl;
    logic [31:0] vmx_flag = '0;
    logic        busy, done, err;
    logic [7:0]  tiles_done;
    logic [31:0] perf_cycles;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    vmx_tile_sched #(.ADDR_W(8), .CNT_W(8), .TMO_W(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_rbase(cmd_rbase), .i_cmd_wbase(cmd_wbase),
        .i_cmd_rstride(cmd_rstride), .i_cmd_wstride(cmd_wstride),
        .i_cmd_ntiles(cmd_ntiles), .i_abort(abort),
        .o_vmx_rbase(vmx_rbase), .o_vmx_wbase(vmx_wbase),
        .o_vmx_ctrl(vmx_ctrl), .i_vmx_flag(vmx_flag),
        .o_busy(busy), .o_done(done), .o_tiles_done(tiles_done),
        .o_err(err), .o_perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // engine responder: after a start pulse waits eng_delay cycles, then is busy for eng_len cycles
    bit eng_respond = 1'b1;
    int eng_delay = 0, eng_len = 10, eng_pend = -1, eng_left = 0;

    always @(posedge clk) begin
        #1;
        if (rst || vmx_ctrl[0]) begin
            eng_pend = -1;
            eng_left = 0;
            vmx_flag = {29'($urandom), 3'b000};
        end else begin
            if (eng_left > 0) begin
                eng_left--;
                if (eng_left == 0) vmx_flag = {29'($urandom), 3'b000};
            end else if (eng_pend > 0) begin
                eng_pend--;
            end else if (eng_pend == 0) begin
                vmx_flag = {29'($urandom), 3'($urandom_range(1, 7))};
                eng_left = eng_len;
                eng_pend = -1;
            end
            if (vmx_ctrl[1] && eng_respond) eng_pend = eng_delay;
        end
    end

    // observation of one job
    logic [15:0] start_q[$];
    int start_cyc_q[$];
    int fall_q[$];
    int acc_cyc, done_cnt, done_first, busy_cnt, soft_cnt, soft_first, err_first, stab_viol;
    logic [2:0] prev_st = 3'd0;

    always @(negedge clk) begin
        if (rst) begin
            prev_st = 3'd0;
        end else begin
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (vmx_ctrl[1]) begin
                start_q.push_back({vmx_rbase, vmx_wbase});
                start_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                if (done_first < 0) done_first = cyc;
            end
            if (busy) busy_cnt++;
            if (vmx_ctrl[0]) begin
                soft_cnt++;
                if (soft_first < 0) soft_first = cyc;
            end
            if (err && err_first < 0) err_first = cyc;
            if (prev_st != 3'd0 && vmx_flag[2:0] == 3'd0) fall_q.push_back(cyc);
            if (vmx_flag[2:0] != 3'd0 && start_q.size() > 0 && {vmx_rbase, vmx_wbase} != start_q[$])
                stab_viol++;
            prev_st = vmx_flag[2:0];
        end
    end

    task automatic clear_mon();
        start_q.delete(); start_cyc_q.delete(); fall_q.delete();
        acc_cyc = -1; done_cnt = 0; done_first = -1; busy_cnt = 0;
        soft_cnt = 0; soft_first = -1; err_first = -1; stab_viol = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tmo_chk(input string nm, input int k, input int budget);
        n_cmp++;
        if (k >= budget) begin
            n_bad++;
            $display("FAIL %s: condition not reached in %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #2;
            if (cmd_ready) break;
        end
        tmo_chk({tag, " idle_wait"}, k, budget);
    endtask

    task automatic issue_cmd(input logic [7:0] rb, input logic [7:0] wb, input logic [7:0] rs,
                             input logic [7:0] ws, input logic [7:0] n);
        @(posedge clk); #2;
        cmd_valid = 1'b1;
        cmd_rbase = rb; cmd_wbase = wb; cmd_rstride = rs; cmd_wstride = ws; cmd_ntiles = n;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        cmd_ntiles = 8'($urandom);
    endtask

    function automatic logic [7:0] exp_addr(input logic [7:0] b, input logic [7:0] s, input int i);
        return 8'((int'(b) + i * int'(s)) % 256);
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, " cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " vmx_ctrl"}, vmx_ctrl, 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " tiles_done"}, 32'(tiles_done), 0);
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " vmx_rbase"}, 32'(vmx_rbase), 0);
        chk({tag, " vmx_wbase"}, 32'(vmx_wbase), 0);
        chk({tag, " perf_cycles"}, perf_cycles, 0);
    endtask

    typedef struct {
        logic [7:0] rb, wb, rs, ws;
        int         n, dly, len;
        int         exp_tiles, exp_done;
        logic [7:0] exp_rb, exp_wb;
    } vec_t;

    task automatic run_job(input vec_t v, input string tag);
        int m;
        eng_respond = 1'b1; eng_delay = v.dly; eng_len = v.len;
        clear_mon();
        issue_cmd(v.rb, v.wb, v.rs, v.ws, 8'(v.n));
        wait_idle(tag, 400);
        repeat (2) @(posedge clk);
        #2;
        chk({tag, " start_count"}, start_q.size(), v.n);
        m = (start_q.size() < v.n) ? start_q.size() : v.n;
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s start%0d rbase", tag, i), 32'(start_q[i][15:8]), 32'(exp_addr(v.rb, v.rs, i)));
            chk($sformatf("%s start%0d wbase", tag, i), 32'(start_q[i][7:0]), 32'(exp_addr(v.wb, v.ws, i)));
        end
        chk({tag, " done_count"}, done_cnt, v.exp_done);
        chk({tag, " tiles_done"}, 32'(tiles_done), v.exp_tiles);
        chk({tag, " final_rbase"}, 32'(vmx_rbase), 32'(v.exp_rb));
        chk({tag, " final_wbase"}, 32'(vmx_wbase), 32'(v.exp_wb));
        chk({tag, " err"}, 32'(err), 0);
        chk({tag, " addr_stable"}, stab_viol, 0);
        chk({tag, " soft_rst_count"}, soft_cnt, 0);
        if (v.n == 0) begin
            chk({tag, " done_latency"}, done_first - acc_cyc, 1);
            chk({tag, " busy_cycles"}, busy_cnt, 0);
        end else begin
            chk({tag, " first_start_latency"}, (start_cyc_q.size() > 0) ? start_cyc_q[0] - acc_cyc : -1, 1);
            for (int i = 1; i < m; i++)
                chk($sformatf("%s restart%0d_latency", tag, i),
                    (fall_q.size() >= i) ? start_cyc_q[i] - fall_q[i-1] : -1, 2);
        end
`ifdef VMX_SCHED_PERF_EN
        chk({tag, " perf_cycles"}, perf_cycles, busy_cnt);
`else
        chk({tag, " perf_cycles"}, perf_cycles, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        int   k;
        int   a_cyc;

        tbl[0] = '{8'h00, 8'h80, 8'h04, 8'h08, 3, 0, 10, 3, 1, 8'h08, 8'h90};
        tbl[1] = '{8'h33, 8'h44, 8'h01, 8'h01, 0, 1, 3,  0, 1, 8'h33, 8'h44};
        tbl[2] = '{8'hFC, 8'h10, 8'h04, 8'h01, 2, 2, 5,  2, 1, 8'h00, 8'h11};
        tbl[3] = '{8'h10, 8'h20, 8'hF0, 8'hF8, 4, 3, 1,  4, 1, 8'hE0, 8'h08};
        tbl[4] = '{8'hAA, 8'h55, 8'h01, 8'h01, 1, 0, 12, 1, 1, 8'hAA, 8'h55};

        repeat (3) @(posedge clk);
        #2;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_job(tbl[i], $sformatf("tbl%0d", i));

        for (int j = 0; j < 12; j++) begin
            v.rb = 8'($urandom); v.wb = 8'($urandom);
            v.rs = 8'($urandom); v.ws = 8'($urandom);
            v.n = $urandom_range(0, 5);
            v.dly = $urandom_range(0, 3);
            v.len = $urandom_range(1, 12);
            v.exp_tiles = v.n;
            v.exp_done = 1;
            v.exp_rb = exp_addr(v.rb, v.rs, (v.n == 0) ? 0 : v.n - 1);
            v.exp_wb = exp_addr(v.wb, v.ws, (v.n == 0) ? 0 : v.n - 1);
            run_job(v, $sformatf("rnd%0d", j));
        end

        // watchdog: engine never leaves idle
        eng_respond = 1'b0;
        clear_mon();
        issue_cmd(8'h40, 8'h50, 8'h01, 8'h01, 8'd2);
        wait_idle("tmo", 100);
        repeat (2) @(posedge clk);
        #2;
        chk("tmo err_latency", err_first - acc_cyc, 17);
        chk("tmo soft_rst_start", soft_first - acc_cyc, 17);
        chk("tmo soft_rst_count", soft_cnt, 2);
        chk("tmo done_count", done_cnt, 0);
        chk("tmo start_count", start_q.size(), 1);
        chk("tmo tiles_done", 32'(tiles_done), 0);
        chk("tmo err_sticky", 32'(err), 1);
        run_job(tbl[4], "post_tmo");

        // abort during tile 2 of 4
        eng_respond = 1'b1; eng_delay = 0; eng_len = 10;
        clear_mon();
        issue_cmd(8'h20, 8'h40, 8'h01, 8'h02, 8'd4);
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #2;
            if (start_q.size() == 2 && vmx_flag[2:0] != 3'd0) break;
        end
        tmo_chk("abort reach_tile2", k, 200);
        repeat (3) @(posedge clk);
        #2;
        abort = 1'b1;
        a_cyc = cyc;
        repeat (3) @(posedge clk);
        #2;
        abort = 1'b0;
        wait_idle("abort", 50);
        repeat (2) @(posedge clk);
        #2;
        chk("abort flush_latency", soft_first - a_cyc, 1);
        chk("abort soft_rst_count", soft_cnt, 2);
        chk("abort done_count", done_cnt, 0);
        chk("abort tiles_done", 32'(tiles_done), 1);
        chk("abort start_count", start_q.size(), 2);
        chk("abort err", 32'(err), 0);

        // asynchronous reset mid-tile
        clear_mon();
        issue_cmd(8'h10, 8'h60, 8'h08, 8'h08, 8'd3);
        for (k = 0; k < 200; k++) begin
            @(posedge clk); #2;
            if (start_q.size() == 2 && vmx_flag[2:0] != 3'd0) break;
        end
        tmo_chk("midrst reach_tile2", k, 200);
        #1;
        rst = 1'b1;
        #1;
        check_reset("midrst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_job(tbl[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
